// File: rtl/branch_predict_fetch_pkg.sv
// Shared constants, BTB update opcodes and small helpers for the predicted-fetch stage.
package branch_predict_fetch_pkg;

    // 2-bit saturating direction counter encodings
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // What the resolving ID instruction does to its BTB entry this cycle
    typedef enum logic [1:0] {
        BTB_NOP,
        BTB_TRAIN,
        BTB_ALLOC,
        BTB_INVAL
    } btb_op_e;

    // Ceiling log2 for elaboration-time sizing
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // One training step of a saturating counter toward the resolved direction
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] result;
        result = ctr;
        if (taken && (ctr != CTR_ST)) begin
            result = ctr + 2'd1;
        end else if (!taken && (ctr != CTR_SNT)) begin
            result = ctr - 2'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/branch_predict_fetch_btb_ram.sv
// BTB entry storage: two async read ports (fetch lookup, ID update lookup) and one sync write port.
// Only valid and ctr are reset; tag and target are don't-care while an entry is invalid.
module branch_predict_fetch_btb_ram
    import branch_predict_fetch_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int TAG_W   = XLEN - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] fetch_idx_i,
    output logic             fetch_valid_o,
    output logic [TAG_W-1:0] fetch_tag_o,
    output logic [XLEN-1:0]  fetch_target_o,
    output logic             fetch_ctr_msb_o,
    input  logic [IDX_W-1:0] upd_idx_i,
    output logic             upd_valid_o,
    output logic [TAG_W-1:0] upd_tag_o,
    output logic [XLEN-1:0]  upd_target_o,
    output logic [1:0]       upd_ctr_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_valid_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [XLEN-1:0]  wr_target_i,
    input  logic [1:0]       wr_ctr_i
);

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];

    // Valid bits and counters: async reset to empty / weakly-not-taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_WNT;
            end
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= wr_valid_i;
            ctr_q[wr_idx_i]   <= wr_ctr_i;
        end
    end

    // Tag and target payload: plain write-enabled storage
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]    <= wr_tag_i;
            target_q[wr_idx_i] <= wr_target_i;
        end
    end

    assign fetch_valid_o   = valid_q[fetch_idx_i];
    assign fetch_tag_o     = tag_q[fetch_idx_i];
    assign fetch_target_o  = target_q[fetch_idx_i];
    assign fetch_ctr_msb_o = ctr_q[fetch_idx_i][1];

    assign upd_valid_o  = valid_q[upd_idx_i];
    assign upd_tag_o    = tag_q[upd_idx_i];
    assign upd_target_o = target_q[upd_idx_i];
    assign upd_ctr_o    = ctr_q[upd_idx_i];

endmodule

// File: rtl/branch_predict_fetch.sv
// IF stage with a direct-mapped BTB: predicts next PC every cycle, repairs on ID resolution,
// and keeps saturating branch / mispredict statistics.
module branch_predict_fetch
    import branch_predict_fetch_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    output logic [XLEN-1:0]  pc_out,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic             id_is_branch,
    input  logic             id_taken,
    input  logic [XLEN-1:0]  id_target,
    input  logic             id_pred_taken,
    input  logic [XLEN-1:0]  id_pred_target,
    output logic             flush_ifid,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int              IDX_W   = clog2(BTB_ENTRIES);
    localparam int              TAG_W   = XLEN - IDX_W - 2;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic             fetch_valid;
    logic [TAG_W-1:0] fetch_tag_rd;
    logic [XLEN-1:0]  fetch_target;
    logic             fetch_ctr_msb;
    logic             fetch_hit;

    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_valid;
    logic [TAG_W-1:0] upd_tag_rd;
    logic [XLEN-1:0]  upd_target;
    logic [1:0]       upd_ctr;
    logic             upd_hit;

    btb_op_e          btb_op;
    logic             wr_en;
    logic             wr_valid;
    logic [TAG_W-1:0] wr_tag;
    logic [XLEN-1:0]  wr_target;
    logic [1:0]       wr_ctr;

    logic             mispredict;
    logic [XLEN-1:0]  correct_pc;

    branch_predict_fetch_btb_ram #(
        .XLEN    (XLEN),
        .ENTRIES (BTB_ENTRIES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_btb_ram (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_idx_i     (fetch_idx),
        .fetch_valid_o   (fetch_valid),
        .fetch_tag_o     (fetch_tag_rd),
        .fetch_target_o  (fetch_target),
        .fetch_ctr_msb_o (fetch_ctr_msb),
        .upd_idx_i       (upd_idx),
        .upd_valid_o     (upd_valid),
        .upd_tag_o       (upd_tag_rd),
        .upd_target_o    (upd_target),
        .upd_ctr_o       (upd_ctr),
        .wr_en_i         (wr_en),
        .wr_idx_i        (upd_idx),
        .wr_valid_i      (wr_valid),
        .wr_tag_i        (wr_tag),
        .wr_target_i     (wr_target),
        .wr_ctr_i        (wr_ctr)
    );

    // Fetch-side lookup; reads storage as it was before this cycle's update (no bypass)
    assign fetch_idx   = pc_q[IDX_W+1:2];
    assign fetch_tag   = pc_q[XLEN-1:IDX_W+2];
    assign fetch_hit   = fetch_valid && (fetch_tag_rd == fetch_tag);
    assign pred_taken  = fetch_hit && fetch_ctr_msb;
    assign pred_target = fetch_hit ? fetch_target : '0;

    assign upd_idx = id_pc[IDX_W+1:2];
    assign upd_tag = id_pc[XLEN-1:IDX_W+2];
    assign upd_hit = upd_valid && (upd_tag_rd == upd_tag);

    // Mispredict detection: wrong direction, wrong target, or a non-branch that was predicted taken
    always_comb begin
        mispredict = 1'b0;
        if (id_valid) begin
            if (id_is_branch) begin
                if (id_taken != id_pred_taken) begin
                    mispredict = 1'b1;
                end else if (id_taken && (id_target != id_pred_target)) begin
                    mispredict = 1'b1;
                end
            end else if (id_pred_taken) begin
                mispredict = 1'b1;
            end
        end
    end

    assign correct_pc = id_taken ? id_target : (id_pc + PC_STEP);
    assign flush_ifid = mispredict;

    // Choose what the ID-stage instruction does to its BTB slot
    always_comb begin
        btb_op = BTB_NOP;
        if (id_valid && id_is_branch) begin
            if (upd_hit) begin
                btb_op = BTB_TRAIN;
            end else if (id_taken) begin
                btb_op = BTB_ALLOC;
            end
        end else if (id_valid && id_pred_taken) begin
            btb_op = BTB_INVAL;
        end
    end

    // Build the write data; fields not being changed are written back unchanged
    always_comb begin
        wr_en     = 1'b0;
        wr_valid  = upd_valid;
        wr_tag    = upd_tag_rd;
        wr_target = upd_target;
        wr_ctr    = upd_ctr;
        case (btb_op)
            BTB_TRAIN: begin
                wr_en    = 1'b1;
                wr_valid = 1'b1;
                wr_ctr   = ctr_step(upd_ctr, id_taken);
                if (id_taken) begin
                    wr_target = id_target;
                end
            end
            BTB_ALLOC: begin
                wr_en     = 1'b1;
                wr_valid  = 1'b1;
                wr_tag    = upd_tag;
                wr_target = id_target;
                wr_ctr    = CTR_WT;
            end
            BTB_INVAL: begin
                wr_en    = 1'b1;
                wr_valid = 1'b0;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    // Next-PC selection (redirect beats stall) and saturating statistics
    always_comb begin
        pc_d          = pc_q + PC_STEP;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (mispredict) begin
            pc_d = correct_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end
        if (id_valid && id_is_branch && !(&branch_cnt_q)) begin
            branch_cnt_d = branch_cnt_q + 1'b1;
        end
        if (mispredict && !(&mispred_cnt_q)) begin
            mispred_cnt_d = mispred_cnt_q + 1'b1;
        end
    end

    // PC and statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            pc_q          <= pc_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign pc_out      = pc_q;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_fetch.sv
// Bench for branch_predict_fetch: directed scenarios plus a randomized run against an
// array-based reference model of the BTB and PC sequencing.
module tb_branch_predict_fetch;

    localparam int          N    = 4;
    localparam int          SH   = $clog2(N) + 2;
    localparam logic [31:0] RPC  = 32'h400;
    localparam int          CMAX = 15;

    logic        clk = 1'b0;
    logic        rst_n, stall;
    logic [31:0] pc_out, pred_target;
    logic        pred_taken, flush_ifid;
    logic        id_valid, id_is_branch, id_taken, id_pred_taken;
    logic [31:0] id_pc, id_target, id_pred_target;
    logic [3:0]  branch_cnt, mispred_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_predict_fetch #(
        .XLEN        (32),
        .BTB_ENTRIES (N),
        .RESET_PC    (RPC),
        .CNT_W       (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .pc_out         (pc_out),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_is_branch   (id_is_branch),
        .id_taken       (id_taken),
        .id_target      (id_target),
        .id_pred_taken  (id_pred_taken),
        .id_pred_target (id_pred_target),
        .flush_ifid     (flush_ifid),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    // Reference model: one slot per index, counters as plain integers 0..3
    logic [31:0] m_pc;
    bit          m_valid [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    int          m_bcnt, m_mcnt;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic void m_reset();
        m_pc = RPC;
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 1;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
        end
        m_bcnt = 0;
        m_mcnt = 0;
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == (pc >> SH));
    endfunction

    function automatic void m_lookup(input logic [31:0] pc, output bit tk, output logic [31:0] tg);
        tk = m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
        tg = m_hit(pc) ? m_tgt[m_idx(pc)] : 32'h0;
    endfunction

    function automatic bit m_mispredict();
        if (!id_valid) return 0;
        if (!id_is_branch) return id_pred_taken;
        if (id_taken != id_pred_taken) return 1;
        return id_taken && (id_target != id_pred_target);
    endfunction

    // Advance the model by one clock using the currently driven inputs
    function automatic void m_clock();
        logic [31:0] nxt, ptg;
        bit          mp, ptk;
        int          i;
        mp = m_mispredict();
        m_lookup(m_pc, ptk, ptg);
        if (mp)         nxt = id_taken ? id_target : id_pc + 32'd4;
        else if (stall) nxt = m_pc;
        else if (ptk)   nxt = ptg;
        else            nxt = m_pc + 32'd4;
        i = m_idx(id_pc);
        if (id_valid && id_is_branch) begin
            if (m_hit(id_pc)) begin
                if (id_taken) begin
                    if (m_ctr[i] < 3) m_ctr[i]++;
                    m_tgt[i] = id_target;
                end else if (m_ctr[i] > 0) begin
                    m_ctr[i]--;
                end
            end else if (id_taken) begin
                m_valid[i] = 1;
                m_tag[i]   = id_pc >> SH;
                m_tgt[i]   = id_target;
                m_ctr[i]   = 2;
            end
            if (m_bcnt < CMAX) m_bcnt++;
        end else if (id_valid && id_pred_taken) begin
            m_valid[i] = 0;
        end
        if (mp && m_mcnt < CMAX) m_mcnt++;
        m_pc = nxt;
    endfunction

    task automatic idle();
        id_valid       = 1'b0;
        id_pc          = '0;
        id_is_branch   = 1'b0;
        id_taken       = 1'b0;
        id_target      = '0;
        id_pred_taken  = 1'b0;
        id_pred_target = '0;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic br, input logic tk,
                           input logic [31:0] tg, input logic ptk, input logic [31:0] ptg);
        id_valid       = 1'b1;
        id_pc          = pc;
        id_is_branch   = br;
        id_taken       = tk;
        id_target      = tg;
        id_pred_taken  = ptk;
        id_pred_target = ptg;
    endtask

    task automatic tick();
        m_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        stall = 1'b0;
        idle();
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        checks++; if (pc_out !== RPC) begin failures++; $display("FAIL reset_pc: got %h expected %h", pc_out, RPC); end
        checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin failures++; $display("FAIL reset_pred: got %b/%h expected 0/0", pred_taken, pred_target); end
        checks++; if (flush_ifid !== 1'b0) begin failures++; $display("FAIL reset_flush: got %b expected 0", flush_ifid); end
        checks++; if (branch_cnt !== 4'd0 || mispred_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", branch_cnt, mispred_cnt); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++; if (pc_out !== RPC + 32'(4 * k) || pred_taken !== 1'b0) begin failures++; $display("FAIL seq_pc%0d: got %h/%b expected %h/0", k, pc_out, pred_taken, RPC + 32'(4 * k)); end
        end
    endtask

    task automatic test_taken_alloc();
        resolve(32'h404, 1, 1, 32'h500, 0, 32'h0);
        #1;
        checks++; if (flush_ifid !== 1'b1) begin failures++; $display("FAIL alloc_flush: got %b expected 1", flush_ifid); end
        tick();
        idle();
        checks++; if (pc_out !== 32'h500) begin failures++; $display("FAIL alloc_redirect: got %h expected 500", pc_out); end
        checks++; if (mispred_cnt !== 4'd1 || branch_cnt !== 4'd1) begin failures++; $display("FAIL alloc_cnt: got %0d/%0d expected 1/1", mispred_cnt, branch_cnt); end
        resolve(32'h200, 1, 1, 32'h404, 0, 32'h0);
        tick();
        idle();
        checks++; if (pc_out !== 32'h404 || pred_taken !== 1'b1 || pred_target !== 32'h500) begin failures++; $display("FAIL alloc_predict: got %h/%b/%h expected 404/1/500", pc_out, pred_taken, pred_target); end
    endtask

    task automatic test_training();
        resolve(32'h404, 1, 0, 32'h0, 1, 32'h500);
        #1;
        checks++; if (flush_ifid !== 1'b1) begin failures++; $display("FAIL train_flush1: got %b expected 1", flush_ifid); end
        tick();
        resolve(32'h404, 1, 0, 32'h0, 0, 32'h0);
        #1;
        checks++; if (flush_ifid !== 1'b0) begin failures++; $display("FAIL train_flush2: got %b expected 0", flush_ifid); end
        tick();
        resolve(32'h400, 1, 0, 32'h0, 1, 32'h404);
        tick();
        idle();
        checks++; if (pc_out !== 32'h404 || pred_taken !== 1'b0) begin failures++; $display("FAIL train_predict: got %h/%b expected 404/0", pc_out, pred_taken); end
        // one taken from strongly-not-taken must still predict not-taken
        resolve(32'h404, 1, 1, 32'h500, 0, 32'h0);
        tick();
        resolve(32'h400, 1, 0, 32'h0, 1, 32'h404);
        tick();
        idle();
        checks++; if (pc_out !== 32'h404 || pred_taken !== 1'b0) begin failures++; $display("FAIL train_floor: got %h/%b expected 404/0", pc_out, pred_taken); end
    endtask

    task automatic test_stall_redirect();
        stall = 1'b1;
        resolve(32'h300, 1, 1, 32'h600, 0, 32'h0);
        tick();
        idle();
        checks++; if (pc_out !== 32'h600) begin failures++; $display("FAIL stall_redirect: got %h expected 600", pc_out); end
        tick();
        tick();
        checks++; if (pc_out !== 32'h600) begin failures++; $display("FAIL stall_hold: got %h expected 600", pc_out); end
        stall = 1'b0;
    endtask

    task automatic test_alias();
        resolve(32'h10, 1, 1, 32'h80, 0, 32'h0);
        tick();
        resolve(32'h24, 1, 1, 32'h10, 0, 32'h0);
        tick();
        idle();
        stall = 1'b1;
        #1;
        checks++; if (pc_out !== 32'h10 || pred_taken !== 1'b1 || pred_target !== 32'h80) begin failures++; $display("FAIL alias_setup: got %h/%b/%h expected 10/1/80", pc_out, pred_taken, pred_target); end
        resolve(32'h10, 0, 0, 32'h0, 1, 32'h80);
        #1;
        checks++; if (flush_ifid !== 1'b1) begin failures++; $display("FAIL alias_flush: got %b expected 1", flush_ifid); end
        tick();
        idle();
        stall = 1'b0;
        checks++; if (pc_out !== 32'h14) begin failures++; $display("FAIL alias_pc: got %h expected 14", pc_out); end
        resolve(32'h24, 1, 1, 32'h10, 0, 32'h0);
        tick();
        idle();
        checks++; if (pc_out !== 32'h10 || pred_taken !== 1'b0) begin failures++; $display("FAIL alias_inval: got %h/%b expected 10/0", pc_out, pred_taken); end
        checks++; if (mispred_cnt !== 4'(m_mcnt) || branch_cnt !== 4'(m_bcnt)) begin failures++; $display("FAIL alias_cnt: got %0d/%0d expected %0d/%0d", mispred_cnt, branch_cnt, m_mcnt, m_bcnt); end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 20; k++) begin
            resolve(32'h700, 1, (k % 2) == 0, 32'h700, (k % 2) != 0, 32'h0);
            tick();
        end
        checks++; if (mispred_cnt !== 4'd15 || branch_cnt !== 4'd15) begin failures++; $display("FAIL sat_cnt: got %0d/%0d expected 15/15", mispred_cnt, branch_cnt); end
        resolve(32'h700, 1, 1, 32'h900, 0, 32'h0);
        #1 rst_n = 1'b0;
        #1;
        m_reset();
        checks++; if (pc_out !== RPC || mispred_cnt !== 4'd0 || branch_cnt !== 4'd0) begin failures++; $display("FAIL async_reset: got %h/%0d/%0d expected %h/0/0", pc_out, mispred_cnt, branch_cnt, RPC); end
        @(posedge clk);
        #1;
        idle();
        rst_n = 1'b1;
        #1;
        checks++; if (pc_out !== RPC || pred_taken !== 1'b0) begin failures++; $display("FAIL reset_discard: got %h/%b expected %h/0", pc_out, pred_taken, RPC); end
        tick();
        checks++; if (pc_out !== RPC + 32'd4) begin failures++; $display("FAIL reset_resume: got %h expected %h", pc_out, RPC + 32'd4); end
    endtask

    task automatic test_random();
        logic [31:0] pcs [8] = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h410, 32'h500, 32'h10, 32'h14};
        bit          etk;
        logic [31:0] etg;
        for (int k = 0; k < 400; k++) begin
            stall        = ($urandom_range(3) == 0);
            id_valid     = $urandom_range(1);
            id_pc        = pcs[$urandom_range(7)];
            id_is_branch = ($urandom_range(3) != 0);
            id_taken     = id_is_branch ? 1'($urandom_range(1)) : 1'b0;
            id_target    = pcs[$urandom_range(7)];
            if ($urandom_range(1) == 1) begin
                m_lookup(id_pc, etk, etg);
                id_pred_taken  = etk;
                id_pred_target = etg;
            end else begin
                id_pred_taken  = $urandom_range(1);
                id_pred_target = pcs[$urandom_range(7)];
            end
            #1;
            m_lookup(m_pc, etk, etg);
            checks++; if (pred_taken !== etk || pred_target !== etg) begin failures++; $display("FAIL rnd_pred[%0d]: got %b/%h expected %b/%h", k, pred_taken, pred_target, etk, etg); end
            checks++; if (flush_ifid !== m_mispredict()) begin failures++; $display("FAIL rnd_flush[%0d]: got %b expected %b", k, flush_ifid, m_mispredict()); end
            tick();
            checks++; if (pc_out !== m_pc) begin failures++; $display("FAIL rnd_pc[%0d]: got %h expected %h", k, pc_out, m_pc); end
            checks++; if (branch_cnt !== 4'(m_bcnt) || mispred_cnt !== 4'(m_mcnt)) begin failures++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d expected %0d/%0d", k, branch_cnt, mispred_cnt, m_bcnt, m_mcnt); end
        end
        idle();
        stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_taken_alloc();
        test_training();
        test_stall_redirect();
        test_alias();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/branch_predict_fetch.md
Name: branch_predict_fetch

Overview:
- Parametrised successor to the pipelined processor's IF stage.
- Holds the PC and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and predicts next-PC every cycle.
- Takes branch/jump resolution from ID and issues a redirect plus an IF/ID flush on mispredict.
- Replaces the fixed "PC+4 unless ID branches" path with predicted fetch and adds mispredict statistics.

Parameters:
XLEN, 32, address/data width
BTB_ENTRIES, 16, number of BTB entries; power of 2, >=2
RESET_PC, 0, PC value loaded on reset
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hazard stall; hold PC when no redirect
pc_out  out  XLEN  current fetch PC
pred_taken  out  1  prediction for instruction at pc_out; pipeline carries it to ID
pred_target  out  XLEN  predicted target for pc_out; valid when pred_taken=1
id_valid  in  1  ID holds a resolved, non-stalled instruction this cycle
id_pc  in  XLEN  PC of the ID instruction
id_is_branch  in  1  ID instruction is beq/bne/j
id_taken  in  1  actual outcome; 1 for j
id_target  in  XLEN  actual target when taken
id_pred_taken  in  1  prediction carried with the ID instruction
id_pred_target  in  XLEN  predicted target carried with the ID instruction
flush_ifid  out  1  flush IF/ID this cycle
branch_cnt  out  CNT_W  resolved branches, saturating
mispred_cnt  out  CNT_W  mispredicts, saturating

Behaviour:
- IDX_W = log2(BTB_ENTRIES). index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2].
- Each entry holds: valid, tag, target, ctr[1:0].
- Lookup is combinational on pc_out. hit = valid && tag match. pred_taken = hit && ctr[1]; pred_target = entry target (0 on miss).
- mispredict = id_valid && one of:
  - id_is_branch && id_taken != id_pred_taken;
  - id_is_branch && id_taken && id_pred_taken && id_target != id_pred_target;
  - !id_is_branch && id_pred_taken (alias).
- Correct PC: id_taken ? id_target : id_pc+4.
- flush_ifid = mispredict, combinational, same cycle.
- Next PC priority: mispredict -> correct PC; else stall -> hold; else pred_taken -> pred_target; else pc_out+4. PC wraps modulo 2^XLEN.
- Mispredict overrides stall. Callers must drive id_valid=0 while ID is stalled on an operand hazard.
- BTB update on clock edge when id_valid && id_is_branch:
  - hit at id_pc: ctr increments (id_taken) or decrements, saturating at 0/3; target written when taken.
  - miss and taken: allocate entry (overwrite): valid=1, tag, target, ctr=2'b10.
  - miss and not taken: no change.
- Alias case (!id_is_branch && id_pred_taken): entry at id_pc index is invalidated.
- Same-cycle lookup of an entry being updated returns the old contents; no bypass.
- branch_cnt increments when id_valid && id_is_branch. mispred_cnt increments on mispredict. Both hold at all-ones.
- Reset, asynchronous on rst_n low: pc_out=RESET_PC, all valid=0, ctr=2'b01, counters=0.
- Outputs during reset: pred_taken=0, pred_target=0, flush_ifid=0 when id_valid=0.
- Reset mid-redirect discards the redirect.
- Latency: redirect takes effect on pc_out one cycle after mispredict. Prediction is zero-cycle.

Decomposition:
- Shared package constants: CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11; helper function clog2.
- One sub-module, btb_ram: entry storage with async read, sync write, and async reset of valid/ctr.

Test Plan:
1. Reset with RESET_PC=0x400, no ID activity, 3 cycles -> pc_out 0x400, 0x404, 0x408, 0x40C; pred_taken=0 throughout.
2. Taken beq resolves: id_pc=0x404, id_taken=1, id_target=0x500, id_pred_taken=0.
   - Same cycle: flush_ifid=1. Next cycle: pc_out=0x500. mispred_cnt=1.
   - Later fetch of 0x404: pred_taken=1, pred_target=0x500.
3. Counter training: same branch resolved not-taken twice with predictions matching.
   - ctr goes 10 -> 01 after first; 01 -> 00 after second.
   - Only the first resolution (predicted taken) flushes.
   - Third fetch of 0x404: pred_taken=0.
4. Simultaneous stall=1 and mispredict to 0x600 -> pc_out=0x600 next cycle. With stall=1 and no mispredict -> pc_out holds.
5. Alias check, BTB_ENTRIES=4: branch at 0x10 allocated taken to 0x80; a non-branch reaches ID with id_pred_taken=1, id_pc=0x10 -> flush_ifid=1, next pc=0x14, entry invalidated.
6. Saturation with CNT_W=4: 20 mispredicts -> mispred_cnt=15. Assert rst_n low mid-stream -> counters=0 and pc_out=RESET_PC immediately, without a clock edge.
